// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if: request, response and ALU-side buses of the nibble sequencer.
// rsp_zero exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_s;
  logic         req_m;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_r;
  logic         rsp_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         rsp_zero;
`endif
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_pin;
  logic [3:0]   alu_r;
  logic         alu_pout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready, alu_r, alu_pout,
    output req_ready, rsp_valid, rsp_r, rsp_cout, rsp_zero, alu_a, alu_b, alu_s, alu_m, alu_pin
  );
  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready, alu_r, alu_pout,
    input  req_ready, rsp_valid, rsp_r, rsp_cout, rsp_zero, alu_a, alu_b, alu_s, alu_m, alu_pin
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready, alu_r, alu_pout,
    output req_ready, rsp_valid, rsp_r, rsp_cout, alu_a, alu_b, alu_s, alu_m, alu_pin
  );
  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready, alu_r, alu_pout,
    input  req_ready, rsp_valid, rsp_r, rsp_cout, alu_a, alu_b, alu_s, alu_m, alu_pin
  );
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: issues a wide op to a 4-bit ALU one nibble per cycle, LSB first, chaining carry.
// Optional registered zero flag on rsp_zero when ALU_SEQ_ZERO_FLAG_EN is defined.
module alu_nibble_sequencer #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst_n,
  alu_nibble_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0]  a_q, b_q, r_q, r_nxt;
  logic [3:0]    s_q;
  logic          m_q, cin_q, carry_q;
  logic [IW-1:0] idx;
  logic          last, run;
  assign last = idx == IW'(NIBBLES - 1);
  assign run  = state == RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.req_valid ? RUN : IDLE)
              : state == RUN  ? (last ? DONE : RUN)
              : (bus.rsp_ready ? IDLE : DONE);
    r_nxt = r_q;
    r_nxt[{idx, 2'b00} +: 4] = bus.alu_r;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      r_q     <= '0;
      idx     <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        s_q   <= bus.req_s;
        m_q   <= bus.req_m;
        cin_q <= bus.req_cin;
        idx   <= '0;
      end
      if (run) begin
        r_q     <= r_nxt;
        carry_q <= bus.alu_pout;
        idx     <= last ? idx : idx + IW'(1);
      end
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) zero_q <= 1'b1;
    else if (run && last) zero_q <= ~|r_nxt;
  assign bus.rsp_zero = zero_q;
`endif
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_r     = r_q;
  assign bus.rsp_cout  = carry_q;
  // ALU drive is forced to zero outside RUN; carry is chained regardless of mode
  assign bus.alu_a   = run ? a_q[{idx, 2'b00} +: 4] : 4'h0;
  assign bus.alu_b   = run ? b_q[{idx, 2'b00} +: 4] : 4'h0;
  assign bus.alu_s   = run ? s_q : 4'h0;
  assign bus.alu_m   = run & m_q;
  assign bus.alu_pin = run & (idx == '0 ? cin_q : carry_q);
endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle control block driving the 4-bit parallel ALU from the core side. It accepts a wide operation (operands, S/M function select, carry-in) over a valid/ready handshake. It then issues the operation to the ALU one nibble per cycle, LSB first, chaining the ALU carry-out into the next nibble's carry-in. It returns the assembled wide result and final carry over a second valid/ready handshake.

## Interface
- NIBBLES, default 4, number of 4-bit slices per operation (operand width 4*NIBBLES); legal range 1–16.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a, req_b  in  4*NIBBLES  operands.
- req_s  in  4  ALU function select.
- req_m  in  1  ALU mode.
- req_cin  in  1  carry-in for nibble 0.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_r  out  4*NIBBLES  assembled result.
- rsp_cout  out  1  ALU carry-out of the last nibble.
- rsp_zero  out  1  rsp_r == 0; present only with ALU_SEQ_ZERO_FLAG_EN.
- alu_a, alu_b  out  4  current nibble operands to ALU.
- alu_s  out  4  function select to ALU.
- alu_m  out  1  mode to ALU.
- alu_pin  out  1  carry-in to ALU.
- alu_r  in  4  ALU result, combinational from alu_* outputs.
- alu_pout  in  1  ALU carry-out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch a, b, s, m, cin; idx<=0; go RUN.
- RUN: alu_a/alu_b = latched nibble idx; alu_s/alu_m = latched s/m; alu_pin = cin when idx==0, else carry register. Each edge: rsp_r nibble idx <= alu_r; carry <= alu_pout; idx<=idx+1. When idx==NIBBLES-1, go DONE instead of incrementing.
- DONE: rsp_valid=1; rsp_r, rsp_cout (=carry) held stable. On rsp_ready, go IDLE.
- Carry chained for both M values; the ALU ignores it in logic mode.
- req_ready=0 in RUN and DONE; req_valid is ignored there. req_* changes after acceptance have no effect.
- In IDLE and DONE: alu_a, alu_b, alu_s, alu_pin = 0, alu_m = 0.
- Reset values: req_ready=1 (after reset release), rsp_valid=0, rsp_r=0, rsp_cout=0, rsp_zero=1, all alu_* = 0.
- Reset mid-RUN or mid-DONE: in-flight operation is dropped and nothing is returned.

## Timing
- All alu_* outputs are driven from registers only. There is no combinational path from req_* or rsp_ready to any output.
- The ALU path (alu_* to alu_r/alu_pout) is combinational within one cycle.
- Latency: the accept edge is T. Nibble k is presented in cycle T+1+k and captured at edge T+1+k. rsp_valid rises after edge T+NIBBLES.
- Response handshake at edge U: req_ready=1 after U. The next request can be accepted at U+1 at the earliest, giving a one-cycle bubble. Throughput is one operation per NIBBLES+2 cycles.
- NIBBLES=1: a single RUN cycle, and rsp_valid follows the accept edge by one edge.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: rsp_zero port exists and is registered on entry to DONE as the NOR of the full result. It is valid whenever rsp_valid=1 and held with rsp_r.
- Undefined: rsp_zero port and its logic are absent. All other behaviour is identical.

## Test plan
Bench ALU model for all scenarios: R=(A+B+Pin)[3:0], Pout=carry. NIBBLES=4.
- Add with ripple: a=0x0FFF, b=0x0001, cin=0 -> rsp_r=0x1000, rsp_cout=0, rsp_zero=0. rsp_valid rises exactly 4 edges after accept.
- Overflow to zero: a=0xFFFF, b=0x0001, cin=0 -> rsp_r=0x0000, rsp_cout=1, rsp_zero=1 (macro defined).
- Nibble trace: a=0x4321, b=0x8765, cin=1, s=0x9, m=0 -> alu_a 1,2,3,4; alu_b 5,6,7,8; alu_s=0x9 every RUN cycle; alu_pin=1 on the first cycle; rsp_r=0xCA87.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_r/rsp_cout stable and req_ready=0 throughout. A pulsing req_valid with new operands is not accepted. req_ready=1 the cycle after handshake.
- Reset mid-RUN: assert rst_n=0 after 2 nibbles -> all outputs at reset values immediately. The next request a=0x0001, b=0x0001 -> rsp_r=0x0002.
- Operand stability: change req_a after accept -> result reflects the latched operands only.
